// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle between the scanner (master) and the board/decoder side.
interface keypad_scanner_if #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4
);
  localparam int unsigned CODE_W = $clog2(ROWS * COLS);

  logic [ROWS-1:0]   row;
  logic [COLS-1:0]   col;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_held;

  modport master (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column rotation, tick-rate debounce, press pulse and auto-repeat.
module keypad_scanner #(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 4,
  parameter int unsigned SCAN_DIV     = 10000,
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned REPEAT_TICKS = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  keypad_scanner_if.master  bus
);
  localparam int unsigned CODE_W = $clog2(ROWS * COLS);
  localparam int unsigned TICK_W = $clog2(SCAN_DIV);
  localparam int unsigned DB_W   = $clog2(DEBOUNCE + 1);
  localparam int unsigned REP_W  = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
  localparam int unsigned COL_W  = $clog2(COLS);

  typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

  state_e            state_q;
  logic [ROWS-1:0]   row_m_q, row_s_q, latch_q;
  logic [COLS-1:0]   col_q;
  logic [COL_W-1:0]  col_idx_q;
  logic [TICK_W-1:0] tick_q;
  logic [DB_W-1:0]   db_cnt_q;
  logic [REP_W-1:0]  rep_cnt_q;
  logic [CODE_W-1:0] key_code_q;
  logic              key_valid_q, key_held_q;

  logic              tick;
  logic [CODE_W-1:0] low_row;
  logic [CODE_W-1:0] code_d;

  assign tick = (tick_q == TICK_W'(SCAN_DIV - 1));

  // Lowest set row of the latched pattern wins when several rows share a column.
  always_comb begin
    low_row = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (latch_q[r]) low_row = CODE_W'(r);
    end
    code_d = low_row * CODE_W'(COLS) + CODE_W'(col_idx_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StScan;
      row_m_q     <= '0;
      row_s_q     <= '0;
      latch_q     <= '0;
      col_q       <= COLS'(1);
      col_idx_q   <= '0;
      tick_q      <= '0;
      db_cnt_q    <= '0;
      rep_cnt_q   <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      row_m_q     <= bus.row;
      row_s_q     <= row_m_q;
      key_valid_q <= 1'b0;
      tick_q      <= tick ? '0 : tick_q + TICK_W'(1);

      if (tick) begin
        case (state_q)
          StScan: begin
            if (row_s_q != '0) begin
              latch_q  <= row_s_q;
              db_cnt_q <= DB_W'(1);
              state_q  <= StDebounce;
            end else begin
              col_q     <= {col_q[COLS-2:0], col_q[COLS-1]};
              col_idx_q <= (col_idx_q == COL_W'(COLS - 1)) ? '0 : col_idx_q + COL_W'(1);
            end
          end
          StDebounce: begin
            if (row_s_q != latch_q) begin
              db_cnt_q  <= '0;
              state_q   <= StScan;
              col_q     <= {col_q[COLS-2:0], col_q[COLS-1]};
              col_idx_q <= (col_idx_q == COL_W'(COLS - 1)) ? '0 : col_idx_q + COL_W'(1);
            end else if (db_cnt_q == DB_W'(DEBOUNCE)) begin
              state_q     <= StPressed;
              key_code_q  <= code_d;
              key_valid_q <= 1'b1;
              key_held_q  <= 1'b1;
              rep_cnt_q   <= '0;
            end else begin
              db_cnt_q <= db_cnt_q + DB_W'(1);
            end
          end
          StPressed: begin
            if (row_s_q == '0) begin
              db_cnt_q <= DB_W'(1);
              state_q  <= StRelease;
            end else if (REPEAT_TICKS > 0) begin
              if (rep_cnt_q == REP_W'(REPEAT_TICKS - 1)) begin
                rep_cnt_q   <= '0;
                key_valid_q <= 1'b1;
              end else begin
                rep_cnt_q <= rep_cnt_q + REP_W'(1);
              end
            end
          end
          StRelease: begin
            // A re-press before release qualifies resumes the hold silently.
            if (row_s_q != '0) begin
              state_q <= StPressed;
            end else if (db_cnt_q == DB_W'(DEBOUNCE)) begin
              key_held_q <= 1'b0;
              db_cnt_q   <= '0;
              state_q    <= StScan;
              col_q      <= {col_q[COLS-2:0], col_q[COLS-1]};
              col_idx_q  <= (col_idx_q == COL_W'(COLS - 1)) ? '0 : col_idx_q + COL_W'(1);
            end else begin
              db_cnt_q <= db_cnt_q + DB_W'(1);
            end
          end
          default: state_q <= StScan;
        endcase
      end
    end
  end

  assign bus.col       = col_q;
  assign bus.key_code  = key_code_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench: two scanners (no repeat / repeat every 5 ticks) driven by keypad matrix models.
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] keys_a, keys_b;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          pulses_a = 0;
  int          pulses_b = 0;
  int          stamp_b [0:7];

  keypad_scanner_if #(.ROWS(4), .COLS(4)) bus_a ();
  keypad_scanner_if #(.ROWS(4), .COLS(4)) bus_b ();

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .REPEAT_TICKS(0)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .REPEAT_TICKS(5)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  // Key r*4+c closes row r onto column c.
  always_comb begin
    bus_a.row = '0;
    bus_b.row = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys_a[r*4+c] && bus_a.col[c]) bus_a.row[r] = 1'b1;
        if (keys_b[r*4+c] && bus_b.col[c]) bus_b.row[r] = 1'b1;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_a.key_valid === 1'b1) pulses_a <= pulses_a + 1;
    if (bus_b.key_valid === 1'b1) begin
      if (pulses_b < 8) stamp_b[pulses_b] <= cyc;
      pulses_b <= pulses_b + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_held(input bit sel_b, input logic val, input int budget, input string tag);
    int n = 0;
    while (((sel_b ? bus_b.key_held : bus_a.key_held) !== val) && n < budget) begin
      step(1);
      n++;
    end
    check(tag, 32'(sel_b ? bus_b.key_held : bus_a.key_held), 32'(val));
  endtask

  initial begin
    rst_n  = 1'b0;
    keys_a = '0;
    keys_b = '0;
    for (int i = 0; i < 8; i++) stamp_b[i] = 0;

    // 1: reset state and column rotation every 4 clk
    step(5);
    check("rst_col_a", 32'(bus_a.col), 32'h1);
    check("rst_code_a", 32'(bus_a.key_code), 32'h0);
    check("rst_valid_a", 32'(bus_a.key_valid), 32'h0);
    check("rst_held_a", 32'(bus_a.key_held), 32'h0);
    check("rst_col_b", 32'(bus_b.col), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);  check("col_e3", 32'(bus_a.col), 32'h1);
    step(1);  check("col_e4", 32'(bus_a.col), 32'h2);
    step(4);  check("col_e8", 32'(bus_a.col), 32'h4);
    step(4);  check("col_e12", 32'(bus_a.col), 32'h8);
    step(4);  check("col_e16", 32'(bus_a.col), 32'h1);

    // 2: row2 on col1 -> code 9, exact latency, frozen column, release timing
    keys_a[9] = 1'b1;
    step(19);
    check("press_held_early", 32'(bus_a.key_held), 32'h0);
    check("press_valid_early", 32'(bus_a.key_valid), 32'h0);
    step(1);
    check("press_held", 32'(bus_a.key_held), 32'h1);
    check("press_valid", 32'(bus_a.key_valid), 32'h1);
    check("press_code", 32'(bus_a.key_code), 32'd9);
    check("press_col", 32'(bus_a.col), 32'h2);
    step(1);
    check("pulse_one_clk", 32'(bus_a.key_valid), 32'h0);
    step(39);
    check("hold_held", 32'(bus_a.key_held), 32'h1);
    check("hold_col_frozen", 32'(bus_a.col), 32'h2);
    check("hold_single_pulse", 32'(pulses_a), 32'd1);
    keys_a = '0;
    step(15);
    check("release_held_early", 32'(bus_a.key_held), 32'h1);
    step(1);
    check("release_held", 32'(bus_a.key_held), 32'h0);
    check("release_col", 32'(bus_a.col), 32'h4);
    check("release_code_kept", 32'(bus_a.key_code), 32'd9);

    // 3: row0 on col3 toggling every tick never qualifies
    keys_a[3] = 1'b1;
    step(8);
    for (int i = 0; i < 10; i++) begin
      keys_a[3] = ~keys_a[3];
      step(4);
    end
    keys_a = '0;
    step(20);
    check("bounce_held", 32'(bus_a.key_held), 32'h0);
    check("bounce_pulses", 32'(pulses_a), 32'd1);

    // 4: rows 1 and 3 on col0 -> lowest row wins, single pulse
    keys_a[4]  = 1'b1;
    keys_a[12] = 1'b1;
    wait_held(1'b0, 1'b1, 200, "multi_held");
    check("multi_code", 32'(bus_a.key_code), 32'd4);
    step(40);
    check("multi_pulses", 32'(pulses_a), 32'd2);
    keys_a = '0;
    wait_held(1'b0, 1'b0, 200, "multi_release");

    // 5: auto-repeat every 5 ticks (20 clk) on the second scanner
    keys_b[14] = 1'b1;
    wait_held(1'b1, 1'b1, 200, "rep_held");
    check("rep_code", 32'(bus_b.key_code), 32'd14);
    step(70);
    keys_b = '0;
    wait_held(1'b1, 1'b0, 200, "rep_release");
    check("rep_pulses", 32'(pulses_b), 32'd4);
    check("rep_gap1", 32'(stamp_b[1] - stamp_b[0]), 32'd20);
    check("rep_gap2", 32'(stamp_b[2] - stamp_b[1]), 32'd20);
    check("rep_gap3", 32'(stamp_b[3] - stamp_b[2]), 32'd20);

    // 6: reset while pressed aborts; key still down re-qualifies after full debounce
    keys_a[6] = 1'b1;
    wait_held(1'b0, 1'b1, 200, "pre_rst_held");
    step(10);
    check("pre_rst_pulses", 32'(pulses_a), 32'd3);
    rst_n = 1'b0;
    step(1);
    check("mid_rst_held", 32'(bus_a.key_held), 32'h0);
    check("mid_rst_valid", 32'(bus_a.key_valid), 32'h0);
    check("mid_rst_code", 32'(bus_a.key_code), 32'h0);
    check("mid_rst_col", 32'(bus_a.col), 32'h1);
    rst_n = 1'b1;
    step(23);
    check("requal_held_early", 32'(bus_a.key_held), 32'h0);
    check("requal_no_pulse", 32'(pulses_a), 32'd3);
    step(1);
    check("requal_held", 32'(bus_a.key_held), 32'h1);
    check("requal_valid", 32'(bus_a.key_valid), 32'h1);
    check("requal_code", 32'(bus_a.key_code), 32'd6);
    keys_a = '0;
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
